// File: rtl/prewish_pattern_sequencer.sv
// prewish_pattern_sequencer: plays a small pattern table into blinky.
// Table writes come in on STB_I/ADR_I/DAT_I; playback drives STB_O/DAT_O.
module prewish_pattern_sequencer #(
   parameter int PAT_ADDR_BITS = 2,
   parameter int HOLD_BITS     = 8
) (
   input  logic                     CLK_I,
   input  logic                     RST_I,
   input  logic                     STB_I,
   input  logic [PAT_ADDR_BITS-1:0] ADR_I,
   input  logic [7:0]               DAT_I,
   input  logic                     RUN_I,
   input  logic [PAT_ADDR_BITS-1:0] LAST_I,
   input  logic [HOLD_BITS-1:0]     HOLD_I,
   output logic                     STB_O,
   output logic [7:0]               DAT_O,
   output logic [PAT_ADDR_BITS-1:0] IDX_O,
   output logic                     BUSY_O
);

   localparam int NPAT = 2 ** PAT_ADDR_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EMIT,
      S_HOLD
   } state_t;

   state_t                   r_state;
   logic [7:0]               r_tab [NPAT];
   logic                     r_stb_q;
   logic [PAT_ADDR_BITS-1:0] r_idx;
   logic [PAT_ADDR_BITS-1:0] r_idx_o;
   logic [HOLD_BITS-1:0]     r_cnt;
   logic                     r_stb_o;
   logic [7:0]               r_dat_o;
   logic                     r_busy;

   logic                     w_wr;
   logic [PAT_ADDR_BITS-1:0] w_next_idx;

   assign w_wr       = STB_I & ~r_stb_q;
   assign w_next_idx = (r_idx >= LAST_I) ? '0
                     : PAT_ADDR_BITS'(r_idx + 1'b1);

   assign STB_O  = r_stb_o;
   assign DAT_O  = r_dat_o;
   assign IDX_O  = r_idx_o;
   assign BUSY_O = r_busy;

   // Config port: one table write per rising edge of the strobe level.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_stb_q <= 1'b0;
         for (int i = 0; i < NPAT; i++) begin
            r_tab[i] <= 8'h00;
         end
      end else begin
         r_stb_q <= STB_I;
         if (w_wr) begin
            r_tab[ADR_I] <= DAT_I;
         end
      end
   end

   // Playback FSM: emit an entry for one cycle, dwell, advance with wrap.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_idx_o <= '0;
         r_cnt   <= '0;
         r_stb_o <= 1'b0;
         r_dat_o <= 8'h00;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_stb_o <= 1'b0;
               if (RUN_I) begin
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_EMIT;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            S_EMIT: begin
               r_stb_o <= 1'b1;
               r_dat_o <= r_tab[r_idx];
               r_idx_o <= r_idx;
               r_cnt   <= HOLD_I;
               r_busy  <= 1'b1;
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               r_stb_o <= 1'b0;
               if (!RUN_I) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_cnt != '0) begin
                  r_cnt   <= r_cnt - HOLD_BITS'(1);
               end else begin
                  r_idx   <= w_next_idx;
                  r_state <= S_EMIT;
               end
            end
            default: begin
               r_stb_o <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prewish_pattern_sequencer.sv
// tb_prewish_pattern_sequencer: scenario tasks checked against a
// table-and-index reference model of the pattern player.
module tb_prewish_pattern_sequencer;

   logic       clk;
   logic       rst_n;
   logic       stb_i;
   logic [1:0] adr_i;
   logic [7:0] dat_i;
   logic       run_i;
   logic [1:0] last_i;
   logic [7:0] hold_i;
   logic       stb_o;
   logic [7:0] dat_o;
   logic [1:0] idx_o;
   logic       busy_o;

   int n_pass = 0;
   int n_tot  = 0;

   logic [7:0] m_tab [4];

   int         c_got;
   logic [7:0] c_dat [16];
   logic [1:0] c_idx [16];
   int         c_cyc [16];
   logic       c_bsy [16];

   prewish_pattern_sequencer #(
      .PAT_ADDR_BITS(2),
      .HOLD_BITS(8)
   ) dut (
      .CLK_I (clk),
      .RST_I (rst_n),
      .STB_I (stb_i),
      .ADR_I (adr_i),
      .DAT_I (dat_i),
      .RUN_I (run_i),
      .LAST_I(last_i),
      .HOLD_I(hold_i),
      .STB_O (stb_o),
      .DAT_O (dat_o),
      .IDX_O (idx_o),
      .BUSY_O(busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int next_idx(input int i, input int last);
      return (i >= last) ? 0 : i + 1;
   endfunction

   task automatic cfg_write(input int a, input logic [7:0] d,
                            input int len, input logic [7:0] alt);
      stb_i = 1'b1;
      adr_i = 2'(a);
      dat_i = d;
      for (int i = 0; i < len; i++) begin
         if (i == len / 2 && i > 0) dat_i = alt;
         @(negedge clk);
      end
      stb_i = 1'b0;
      m_tab[a] = d;
      @(negedge clk);
   endtask

   task automatic collect(input int n, input int budget);
      c_got = 0;
      for (int k = 1; k <= budget && c_got < n; k++) begin
         @(negedge clk);
         if (stb_o === 1'b1) begin
            c_dat[c_got] = dat_o;
            c_idx[c_got] = idx_o;
            c_cyc[c_got] = k;
            c_bsy[c_got] = busy_o;
            c_got++;
         end
      end
   endtask

   task automatic stop_run();
      run_i = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      int e;
      rst_n = 1'b0; stb_i = 1'b1; adr_i = 2'd1; dat_i = 8'h77;
      run_i = 1'b0; last_i = 2'd0; hold_i = 8'd0;
      for (int i = 0; i < 4; i++) m_tab[i] = 8'h00;
      repeat (3) @(negedge clk);
      n_tot++;
      if (stb_o !== 1'b0) $display("FAIL reset_stb got %b want 0", stb_o);
      else n_pass++;
      n_tot++;
      if (dat_o !== 8'h00) $display("FAIL reset_dat got %h want 00", dat_o);
      else n_pass++;
      n_tot++;
      if (idx_o !== 2'd0) $display("FAIL reset_idx got %0d want 0", idx_o);
      else n_pass++;
      n_tot++;
      if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      m_tab[1] = 8'h77;
      stb_i = 1'b0;
      @(negedge clk);
      last_i = 2'd1; hold_i = 8'd1; run_i = 1'b1;
      collect(3, 30);
      n_tot++;
      if (c_got !== 3) $display("FAIL empty_count got %0d want 3", c_got);
      else n_pass++;
      e = 0;
      for (int i = 0; i < c_got; i++) begin
         n_tot++;
         if (c_dat[i] !== m_tab[e] || c_idx[i] !== 2'(e))
            $display("FAIL empty_play[%0d] got %h/%0d want %h/%0d",
                     i, c_dat[i], c_idx[i], m_tab[e], e);
         else n_pass++;
         e = next_idx(e, 1);
      end
      stop_run();
   endtask

   task automatic test_sequence();
      int e;
      cfg_write(0, 8'hA5, 1, 8'h00);
      cfg_write(1, 8'h3C, 1, 8'h00);
      cfg_write(2, 8'h0F, 1, 8'h00);
      cfg_write(3, 8'hF0, 1, 8'h00);
      last_i = 2'd3; hold_i = 8'd2; run_i = 1'b1;
      collect(5, 40);
      n_tot++;
      if (c_got !== 5) $display("FAIL seq_count got %0d want 5", c_got);
      else n_pass++;
      n_tot++;
      if (c_cyc[0] !== 2) $display("FAIL seq_latency got %0d want 2", c_cyc[0]);
      else n_pass++;
      e = 0;
      for (int i = 0; i < c_got; i++) begin
         n_tot++;
         if (c_dat[i] !== m_tab[e] || c_idx[i] !== 2'(e) || c_bsy[i] !== 1'b1)
            $display("FAIL seq_play[%0d] got %h/%0d/%b want %h/%0d/1",
                     i, c_dat[i], c_idx[i], c_bsy[i], m_tab[e], e);
         else n_pass++;
         if (i > 0) begin
            n_tot++;
            if (c_cyc[i] - c_cyc[i-1] !== 4)
               $display("FAIL seq_period[%0d] got %0d want 4",
                        i, c_cyc[i] - c_cyc[i-1]);
            else n_pass++;
         end
         e = next_idx(e, 3);
      end
      stop_run();
   endtask

   task automatic test_last();
      int e;
      last_i = 2'd1; hold_i = 8'd2; run_i = 1'b1;
      e = 0;
      collect(4, 40);
      for (int i = 0; i < 4; i++) begin
         n_tot++;
         if (i >= c_got || c_dat[i] !== m_tab[e] || c_idx[i] !== 2'(e))
            $display("FAIL last1_play[%0d] got %h/%0d want %h/%0d",
                     i, c_dat[i], c_idx[i], m_tab[e], e);
         else n_pass++;
         e = next_idx(e, 1);
      end
      last_i = 2'd0;
      collect(3, 30);
      for (int i = 0; i < 3; i++) begin
         n_tot++;
         if (i >= c_got || c_dat[i] !== m_tab[e] || c_idx[i] !== 2'(e))
            $display("FAIL last0_play[%0d] got %h/%0d want %h/%0d",
                     i, c_dat[i], c_idx[i], m_tab[e], e);
         else n_pass++;
         e = next_idx(e, 0);
      end
      stop_run();
   endtask

   task automatic test_long_strobe();
      cfg_write(1, 8'h55, 10, 8'h99);
      last_i = 2'd1; hold_i = 8'd0; run_i = 1'b1;
      collect(2, 20);
      n_tot++;
      if (c_got !== 2 || c_dat[1] !== m_tab[1] || c_idx[1] !== 2'd1)
         $display("FAIL long_strobe got %h/%0d want %h/1",
                  c_dat[1], c_idx[1], m_tab[1]);
      else n_pass++;
      stop_run();
   endtask

   task automatic test_stop_restart();
      logic [7:0] last_dat;
      last_i = 2'd3; hold_i = 8'd3; run_i = 1'b1;
      collect(2, 30);
      last_dat = c_dat[1];
      run_i = 1'b0;
      collect(1, 10);
      n_tot++;
      if (c_got !== 0) $display("FAIL stop_pulses got %0d want 0", c_got);
      else n_pass++;
      n_tot++;
      if (busy_o !== 1'b0 || dat_o !== last_dat || idx_o !== 2'd1)
         $display("FAIL stop_hold got %b/%h/%0d want 0/%h/1",
                  busy_o, dat_o, idx_o, last_dat);
      else n_pass++;
      run_i = 1'b1;
      collect(1, 10);
      n_tot++;
      if (c_got !== 1 || c_cyc[0] !== 2 || c_idx[0] !== 2'd0
          || c_dat[0] !== m_tab[0])
         $display("FAIL restart got n=%0d cyc=%0d %h/%0d want 1/2 %h/0",
                  c_got, c_cyc[0], c_dat[0], c_idx[0], m_tab[0]);
      else n_pass++;
      stop_run();
   endtask

   task automatic test_write_running();
      int e;
      logic [7:0] d;
      last_i = 2'd3; hold_i = 8'd15; run_i = 1'b1;
      collect(1, 10);
      d = 8'($urandom_range(0, 255));
      cfg_write(2, d, 1, 8'h00);
      e = 1;
      collect(3, 80);
      for (int i = 0; i < 3; i++) begin
         n_tot++;
         if (i >= c_got || c_dat[i] !== m_tab[e] || c_idx[i] !== 2'(e))
            $display("FAIL wr_run[%0d] got %h/%0d want %h/%0d",
                     i, c_dat[i], c_idx[i], m_tab[e], e);
         else n_pass++;
         e = next_idx(e, 3);
      end
      stop_run();
   endtask

   task automatic test_random();
      int e, last, h, len;
      logic [7:0] d;
      for (int it = 0; it < 4; it++) begin
         for (int a = 0; a < 4; a++) begin
            d   = 8'($urandom_range(0, 255));
            len = $urandom_range(1, 4);
            cfg_write(a, d, len, ~d);
         end
         last = $urandom_range(0, 3);
         h    = $urandom_range(0, 6);
         last_i = 2'(last); hold_i = 8'(h); run_i = 1'b1;
         collect(7, 7 * (h + 2) + 10);
         n_tot++;
         if (c_got !== 7) $display("FAIL rnd_count[%0d] got %0d want 7", it, c_got);
         else n_pass++;
         e = 0;
         for (int i = 0; i < c_got; i++) begin
            n_tot++;
            if (c_dat[i] !== m_tab[e] || c_idx[i] !== 2'(e)
                || (i > 0 && c_cyc[i] - c_cyc[i-1] !== h + 2))
               $display("FAIL rnd_play[%0d.%0d] got %h/%0d want %h/%0d",
                        it, i, c_dat[i], c_idx[i], m_tab[e], e);
            else n_pass++;
            e = next_idx(e, last);
         end
         stop_run();
      end
   endtask

   task automatic test_hold0_reset();
      last_i = 2'd3; hold_i = 8'd0; run_i = 1'b1;
      collect(4, 20);
      for (int i = 1; i < 4; i++) begin
         n_tot++;
         if (i >= c_got || c_cyc[i] - c_cyc[i-1] !== 2)
            $display("FAIL hold0_period[%0d] got %0d want 2",
                     i, c_cyc[i] - c_cyc[i-1]);
         else n_pass++;
      end
      hold_i = 8'd10;
      collect(2, 40);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tot++;
      if (stb_o !== 1'b0 || dat_o !== 8'h00 || idx_o !== 2'd0
          || busy_o !== 1'b0)
         $display("FAIL async_reset got %b/%h/%0d/%b want 0/00/0/0",
                  stb_o, dat_o, idx_o, busy_o);
      else n_pass++;
      run_i = 1'b0;
      for (int i = 0; i < 4; i++) m_tab[i] = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      last_i = 2'd3; hold_i = 8'd0; run_i = 1'b1;
      collect(4, 20);
      for (int i = 0; i < 4; i++) begin
         n_tot++;
         if (i >= c_got || c_dat[i] !== m_tab[i] || c_idx[i] !== 2'(i))
            $display("FAIL post_reset[%0d] got %h/%0d want %h/%0d",
                     i, c_dat[i], c_idx[i], m_tab[i], i);
         else n_pass++;
      end
      stop_run();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_last();
      test_long_strobe();
      test_stop_restart();
      test_write_running();
      test_random();
      test_hold0_reset();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
